victim_cache_ctrl: RTL and testbench

- Sequencing controller for the data-cache victim buffer.
- On every dcache line miss it looks up the victim buffer, then does one of three things: swaps the hit line back into the dcache, inserts the dcache's evicted line, or writes back a dirty victim to memory before overwriting it.
- Owns victim metadata (tags, valid, dirty, replacement pointer) and drives the external victim data array through index/write-enable ports.
- Sits between the dcache miss FSM and the memory write-back port.

---
 rtl/victim_cache_ctrl_if.sv | 33 +++
 rtl/victim_cache_ctrl.sv | 146 ++++++++++++++
 tb/tb_victim_cache_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/victim_cache_ctrl_if.sv
// victim_cache_ctrl_if: miss, victim-array, write-back and statistics signals of the victim buffer controller
interface victim_cache_ctrl_if #(
    parameter int VICTIM_NO_OF_SETS = 4,
    parameter int DCACHE_TAG_BITS = 26
);
    localparam int IW = $clog2(VICTIM_NO_OF_SETS);
    logic dc_miss_req_i;
    logic [DCACHE_TAG_BITS-1:0] dc_miss_addr_i;
    logic dc_evict_valid_i;
    logic dc_evict_dirty_i;
    logic [DCACHE_TAG_BITS-1:0] dc_evict_addr_i;
    logic dc_miss_ack_o;
    logic dc_vc_hit_o;
    logic dc_fill_dirty_o;
    logic [IW-1:0] vc_idx_o;
    logic vc_wr_en_o;
    logic mem_wb_req_o;
    logic [DCACHE_TAG_BITS-1:0] mem_wb_addr_o;
    logic mem_wb_ack_i;
    logic [31:0] stat_hits_o;
    logic [31:0] stat_misses_o;
    logic [31:0] stat_wbs_o;
    modport master (
        output dc_miss_req_i, dc_miss_addr_i, dc_evict_valid_i, dc_evict_dirty_i, dc_evict_addr_i, mem_wb_ack_i,
        input dc_miss_ack_o, dc_vc_hit_o, dc_fill_dirty_o, vc_idx_o, vc_wr_en_o, mem_wb_req_o, mem_wb_addr_o,
        input stat_hits_o, stat_misses_o, stat_wbs_o
    );
    modport slave (
        input dc_miss_req_i, dc_miss_addr_i, dc_evict_valid_i, dc_evict_dirty_i, dc_evict_addr_i, mem_wb_ack_i,
        output dc_miss_ack_o, dc_vc_hit_o, dc_fill_dirty_o, vc_idx_o, vc_wr_en_o, mem_wb_req_o, mem_wb_addr_o,
        output stat_hits_o, stat_misses_o, stat_wbs_o
    );
endinterface

// File: rtl/victim_cache_ctrl.sv
// victim_cache_ctrl: victim buffer lookup/swap/insert/write-back sequencer; VICTIM_CACHE_STATS_EN adds hit/miss/write-back counters
module victim_cache_ctrl #(
    parameter int VICTIM_NO_OF_SETS = 4,
    parameter int DCACHE_LINE_WIDTH = 128,
    parameter int DCACHE_TAG_BITS = 26
) (
    input logic clk,
    input logic rst,
    victim_cache_ctrl_if.slave bus
);
    localparam int N = VICTIM_NO_OF_SETS;
    localparam int IW = $clog2(N);
    localparam int TW = DCACHE_TAG_BITS;
    if (N < 2 || N > 16 || (N & (N - 1)) != 0 || DCACHE_LINE_WIDTH < 1) begin : g_bad_cfg
        $error("victim_cache_ctrl: unsupported configuration");
    end
    typedef enum logic [2:0] {IDLE, LOOKUP, SWAP, WB_REQ, INSERT, DONE} state_t;
    state_t state, state_n;
    logic [TW-1:0] tags [N];
    logic [N-1:0] valid, dirty;
    logic [IW-1:0] rr_ptr, way, tgt, hit_idx, ev_idx, sel;
    logic [TW-1:0] miss_addr, ev_addr;
    logic ev_valid, ev_dirty, hit_r, fill_dirty, lk_hit, ev_hit;
    // descending scan so the lowest matching index is the one left standing
    always_comb begin
        lk_hit = 1'b0;
        hit_idx = '0;
        ev_hit = 1'b0;
        ev_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == miss_addr) begin
                lk_hit = 1'b1;
                hit_idx = IW'(i);
            end
            if (valid[i] && tags[i] == ev_addr) begin
                ev_hit = 1'b1;
                ev_idx = IW'(i);
            end
        end
        sel = ev_hit ? ev_idx : rr_ptr;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        bus.dc_miss_ack_o = 1'b0;
        bus.dc_vc_hit_o = 1'b0;
        bus.dc_fill_dirty_o = 1'b0;
        bus.vc_idx_o = '0;
        bus.vc_wr_en_o = 1'b0;
        bus.mem_wb_req_o = 1'b0;
        bus.mem_wb_addr_o = '0;
        case (state)
            IDLE: state_n = bus.dc_miss_req_i ? LOOKUP : IDLE;
            LOOKUP: state_n = lk_hit ? SWAP : !ev_valid ? DONE : (valid[sel] && dirty[sel]) ? WB_REQ : INSERT;
            SWAP: begin
                bus.vc_idx_o = way;
                bus.vc_wr_en_o = ev_valid;
                state_n = DONE;
            end
            WB_REQ: begin
                bus.vc_idx_o = tgt;
                bus.mem_wb_req_o = 1'b1;
                bus.mem_wb_addr_o = tags[tgt];
                state_n = bus.mem_wb_ack_i ? INSERT : WB_REQ;
            end
            INSERT: begin
                bus.vc_idx_o = tgt;
                bus.vc_wr_en_o = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                bus.dc_miss_ack_o = 1'b1;
                bus.dc_vc_hit_o = hit_r;
                bus.dc_fill_dirty_o = fill_dirty;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < N; i++) tags[i] <= '0;
            valid <= '0;
            dirty <= '0;
            rr_ptr <= '0;
            way <= '0;
            tgt <= '0;
            miss_addr <= '0;
            ev_addr <= '0;
            ev_valid <= 1'b0;
            ev_dirty <= 1'b0;
            hit_r <= 1'b0;
            fill_dirty <= 1'b0;
        end else
            case (state)
                IDLE: if (bus.dc_miss_req_i) begin
                    miss_addr <= bus.dc_miss_addr_i;
                    ev_valid <= bus.dc_evict_valid_i;
                    ev_dirty <= bus.dc_evict_dirty_i;
                    ev_addr <= bus.dc_evict_addr_i;
                    hit_r <= 1'b0;
                    fill_dirty <= 1'b0;
                end
                LOOKUP: begin
                    hit_r <= lk_hit;
                    way <= hit_idx;
                    tgt <= sel;
                end
                SWAP: begin
                    fill_dirty <= dirty[way];
                    if (ev_valid) begin
                        tags[way] <= ev_addr;
                        dirty[way] <= ev_dirty;
                    end else valid[way] <= 1'b0;
                end
                INSERT: begin
                    valid[tgt] <= 1'b1;
                    tags[tgt] <= ev_addr;
                    dirty[tgt] <= ev_dirty;
                    if (tgt == rr_ptr) rr_ptr <= (rr_ptr == IW'(N - 1)) ? '0 : rr_ptr + 1'b1;
                end
                default: ;
            endcase
`ifdef VICTIM_CACHE_STATS_EN
    logic [31:0] hits, misses, wbs;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            hits <= '0;
            misses <= '0;
            wbs <= '0;
        end else begin
            if (state == DONE && hit_r && ~&hits) hits <= hits + 1'b1;
            if (state == DONE && !hit_r && ~&misses) misses <= misses + 1'b1;
            if (state == WB_REQ && bus.mem_wb_ack_i && ~&wbs) wbs <= wbs + 1'b1;
        end
    assign bus.stat_hits_o = hits;
    assign bus.stat_misses_o = misses;
    assign bus.stat_wbs_o = wbs;
`else
    assign bus.stat_hits_o = '0;
    assign bus.stat_misses_o = '0;
    assign bus.stat_wbs_o = '0;
`endif
endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb_victim_cache_ctrl: directed miss-transaction vectors plus reset-during-write-back sequence
module tb_victim_cache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    victim_cache_ctrl_if #(.VICTIM_NO_OF_SETS(4), .DCACHE_TAG_BITS(26)) vif ();
    victim_cache_ctrl #(.VICTIM_NO_OF_SETS(4), .DCACHE_LINE_WIDTH(128), .DCACHE_TAG_BITS(26)) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );
    typedef struct {
        bit pre_rst;
        logic [25:0] miss;
        logic evv;
        logic evd;
        logic [25:0] ea;
        int dly;
        int lat;
        logic hit;
        logic fd;
        logic wr;
        int idx;
        logic [25:0] wba;
        int rr;
        int ent;
        logic e_v;
        logic e_d;
        logic [25:0] e_t;
    } vec_t;
    vec_t vt [19];
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic reset_dut();
        rst = 1'b1;
        vif.dc_miss_req_i = 1'b0;
        vif.mem_wb_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic run(input int id, input vec_t v);
        int cyc = 0, wbc = 0;
        logic seen = 1'b0, wr_seen = 1'b0, stable = 1'b1, hit = 1'b0, fd = 1'b0;
        logic [31:0] widx = '0, wadr = '0, wbi = '0;
        string p = $sformatf("v%0d", id);
        @(posedge clk);
        #1;
        vif.dc_miss_req_i = 1'b1;
        vif.dc_miss_addr_i = v.miss;
        vif.dc_evict_valid_i = v.evv;
        vif.dc_evict_dirty_i = v.evd;
        vif.dc_evict_addr_i = v.ea;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (vif.vc_wr_en_o && !wr_seen) begin
                wr_seen = 1'b1;
                widx = 32'(vif.vc_idx_o);
            end
            if (vif.mem_wb_req_o) begin
                if (wbc == 0) begin
                    wadr = 32'(vif.mem_wb_addr_o);
                    wbi = 32'(vif.vc_idx_o);
                end else if (32'(vif.mem_wb_addr_o) != wadr || 32'(vif.vc_idx_o) != wbi) stable = 1'b0;
                wbc++;
            end
            vif.mem_wb_ack_i = vif.mem_wb_req_o && wbc == v.dly;
            if (vif.dc_miss_ack_o) begin
                seen = 1'b1;
                hit = vif.dc_vc_hit_o;
                fd = vif.dc_fill_dirty_o;
            end
        end
        vif.dc_miss_req_i = 1'b0;
        vif.mem_wb_ack_i = 1'b0;
        chk({p, "_ack_seen"}, 32'(seen), 32'd1);
        chk({p, "_latency"}, 32'(cyc), 32'(v.lat));
        chk({p, "_hit"}, 32'(hit), 32'(v.hit));
        chk({p, "_fill_dirty"}, 32'(fd), 32'(v.fd));
        chk({p, "_wr_en"}, 32'(wr_seen), 32'(v.wr));
        if (v.wr) chk({p, "_wr_idx"}, widx, 32'(v.idx));
        chk({p, "_wb_cycles"}, 32'(wbc), 32'(v.dly));
        if (v.dly > 0) begin
            chk({p, "_wb_addr"}, wadr, 32'(v.wba));
            chk({p, "_wb_stable"}, 32'(stable), 32'd1);
        end
        chk({p, "_rr_ptr"}, 32'(dut.rr_ptr), 32'(v.rr));
        chk({p, "_ent_valid"}, 32'(dut.valid[v.ent]), 32'(v.e_v));
        chk({p, "_ent_dirty"}, 32'(dut.dirty[v.ent]), 32'(v.e_d));
        chk({p, "_ent_tag"}, 32'(dut.tags[v.ent]), 32'(v.e_t));
    endtask
    initial begin
        int cyc;
        logic [31:0] eh, em, ew;
        vt[0]  = '{0, 26'h100, 1, 0, 26'h200, 0, 3, 0, 0, 1, 0, 26'h0, 1, 0, 1, 0, 26'h200};
        vt[1]  = '{1, 26'h300, 1, 0, 26'h10, 0, 3, 0, 0, 1, 0, 26'h0, 1, 0, 1, 0, 26'h10};
        vt[2]  = '{0, 26'h301, 1, 0, 26'h11, 0, 3, 0, 0, 1, 1, 26'h0, 2, 1, 1, 0, 26'h11};
        vt[3]  = '{0, 26'h302, 1, 0, 26'h12, 0, 3, 0, 0, 1, 2, 26'h0, 3, 2, 1, 0, 26'h12};
        vt[4]  = '{0, 26'h303, 1, 0, 26'h13, 0, 3, 0, 0, 1, 3, 26'h0, 0, 3, 1, 0, 26'h13};
        vt[5]  = '{0, 26'h12, 1, 1, 26'h50, 0, 3, 1, 0, 1, 2, 26'h0, 0, 2, 1, 1, 26'h50};
        vt[6]  = '{0, 26'h50, 1, 1, 26'h51, 0, 3, 1, 1, 1, 2, 26'h0, 0, 2, 1, 1, 26'h51};
        vt[7]  = '{0, 26'h400, 1, 1, 26'h10, 0, 3, 0, 0, 1, 0, 26'h0, 1, 0, 1, 1, 26'h10};
        vt[8]  = '{0, 26'h401, 1, 1, 26'h11, 0, 3, 0, 0, 1, 1, 26'h0, 2, 1, 1, 1, 26'h11};
        vt[9]  = '{0, 26'h402, 1, 1, 26'h13, 0, 3, 0, 0, 1, 3, 26'h0, 2, 3, 1, 1, 26'h13};
        vt[10] = '{0, 26'h99, 1, 1, 26'h77, 5, 8, 0, 0, 1, 2, 26'h51, 3, 2, 1, 1, 26'h77};
        vt[11] = '{0, 26'h98, 1, 1, 26'h78, 1, 4, 0, 0, 1, 3, 26'h13, 0, 3, 1, 1, 26'h78};
        vt[12] = '{0, 26'h10, 0, 0, 26'h0, 0, 3, 1, 1, 0, 0, 26'h0, 0, 0, 0, 1, 26'h10};
        vt[13] = '{0, 26'h10, 0, 0, 26'h0, 0, 2, 0, 0, 0, 0, 26'h0, 0, 0, 0, 1, 26'h10};
        vt[14] = '{0, 26'h11, 0, 0, 26'h0, 0, 2, 0, 0, 0, 0, 26'h0, 0, 0, 0, 0, 26'h0};
        vt[15] = '{0, 26'h20, 1, 1, 26'h30, 0, 3, 0, 0, 1, 0, 26'h0, 1, 0, 1, 1, 26'h30};
        vt[16] = '{0, 26'h30, 1, 1, 26'h31, 0, 3, 1, 1, 1, 0, 26'h0, 1, 0, 1, 1, 26'h31};
        vt[17] = '{0, 26'h31, 1, 1, 26'h32, 0, 3, 1, 1, 1, 0, 26'h0, 1, 0, 1, 1, 26'h32};
        vt[18] = '{0, 26'h40, 1, 1, 26'h32, 2, 5, 0, 0, 1, 0, 26'h32, 1, 0, 1, 1, 26'h32};
        vif.dc_miss_addr_i = '0;
        vif.dc_evict_valid_i = 1'b0;
        vif.dc_evict_dirty_i = 1'b0;
        vif.dc_evict_addr_i = '0;
        reset_dut();
        chk("rst_ack", 32'(vif.dc_miss_ack_o), 32'd0);
        chk("rst_wb_req", 32'(vif.mem_wb_req_o), 32'd0);
        chk("rst_wr_en", 32'(vif.vc_wr_en_o), 32'd0);
        chk("rst_idx", 32'(vif.vc_idx_o), 32'd0);
        chk("rst_valid", 32'(dut.valid), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("rst_stat_hits", vif.stat_hits_o, 32'd0);
        for (int i = 0; i < 14; i++) begin
            if (vt[i].pre_rst) reset_dut();
            run(i, vt[i]);
        end
        @(posedge clk);
        #1;
        vif.dc_miss_req_i = 1'b1;
        vif.dc_miss_addr_i = 26'h97;
        vif.dc_evict_valid_i = 1'b1;
        vif.dc_evict_dirty_i = 1'b1;
        vif.dc_evict_addr_i = 26'h11;
        cyc = 0;
        while (!vif.mem_wb_req_o && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("midrst_wb_req_seen", 32'(vif.mem_wb_req_o), 32'd1);
        chk("midrst_wb_addr", 32'(vif.mem_wb_addr_o), 32'h11);
        #2;
        rst = 1'b1;
        vif.dc_miss_req_i = 1'b0;
        #1;
        chk("midrst_wb_req_drop", 32'(vif.mem_wb_req_o), 32'd0);
        chk("midrst_valid", 32'(dut.valid), 32'd0);
        chk("midrst_state_idle", 32'(dut.state), 32'd0);
        chk("midrst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        #2 rst = 1'b0;
        for (int i = 14; i < 19; i++) run(i, vt[i]);
`ifdef VICTIM_CACHE_STATS_EN
        eh = 32'd2;
        em = 32'd3;
        ew = 32'd1;
`else
        eh = 32'd0;
        em = 32'd0;
        ew = 32'd0;
`endif
        chk("stat_hits", vif.stat_hits_o, eh);
        chk("stat_misses", vif.stat_misses_o, em);
        chk("stat_wbs", vif.stat_wbs_o, ew);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
